// File: rtl/ps2_kbd_pkg.sv
// Shared scan-code / LCD-code constants and the sequencer state type
// for the PS/2 keyboard to LCD path.
package ps2_kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam logic [8:0] LCD_LINE0 = 9'h080;
    localparam logic [8:0] LCD_LINE1 = 9'h0C0;
    localparam logic [8:0] LCD_BKSP  = 9'h108;
    localparam logic [8:0] LCD_TAB   = 9'h109;

    typedef enum logic [2:0] {
        IDLE, BRK, EXT, EXT_BRK, MAP, WRAP, EMIT
    } seq_state_e;

    // Anything that is not enter/backspace/tab advances the cursor
    function automatic logic is_char(input logic [8:0] code);
        return (code != LCD_LINE1) && (code != LCD_BKSP) && (code != LCD_TAB);
    endfunction

endpackage

// File: rtl/kbd_cursor_tracker.sv
// Cursor column/line bookkeeping for a 2-line LCD; flags when the next
// character must be preceded by a line-change command.
module kbd_cursor_tracker
    import ps2_kbd_pkg::*;
#(
    parameter int LCD_COLS = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [8:0] i_code,
    input  logic       i_accept,
    output logic       o_need_wrap,
    output logic [8:0] o_wrap_cmd
);

    localparam int CW = $clog2(LCD_COLS + 1);
    localparam logic [CW-1:0] COL_MAX = CW'(LCD_COLS);

    logic [CW-1:0] r_col;
    logic          r_line;

    // Both line commands (enter, replaced enter, inserted wrap) move the cursor
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col  <= '0;
            r_line <= 1'b0;
        end else if (i_accept) begin
            if (i_code == LCD_LINE1 || i_code == LCD_LINE0) begin
                r_line <= ~r_line;
                r_col  <= '0;
            end else if (i_code == LCD_BKSP) begin
                if (r_col != '0)
                    r_col <= r_col - CW'(1);
            end else if (i_code != LCD_TAB && r_col != COL_MAX) begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    assign o_need_wrap = is_char(i_code) && (r_col == COL_MAX);
    assign o_wrap_cmd  = r_line ? LCD_LINE0 : LCD_LINE1;

endmodule

// File: rtl/kbd_lcd_sequencer.sv
// PS/2 scan-code sequencer: prefix/modifier decode, key2lcd drive, and
// valid/ready LCD output with automatic line-wrap insertion.
module kbd_lcd_sequencer
    import ps2_kbd_pkg::*;
#(
    parameter int LCD_COLS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_in,
    input  logic       scan_valid,
    output logic [7:0] kcode,
    output logic       letter_case,
    input  logic [8:0] map_code,
    output logic [8:0] lcd_data,
    output logic       lcd_valid,
    input  logic       lcd_ready,
    output logic       caps_led,
    output logic       overrun
);

    seq_state_e r_state, w_state_nxt;

    logic [7:0] r_kcode;
    logic       r_shift;
    logic       r_caps;
    logic [8:0] r_lcd_data;
    logic       r_lcd_valid;
    logic       r_overrun;
    logic [8:0] r_pend;

    logic       w_accept;
    logic       w_busy;
    logic       w_is_shift;
    logic       w_is_caps;
    logic       w_need_wrap;
    logic [8:0] w_wrap_cmd;
    logic [8:0] w_trk_code;
    logic       w_trk_accept;
    logic [8:0] w_map_sel;

    assign w_accept     = r_lcd_valid && lcd_ready;
    assign w_busy       = (r_state == MAP) || (r_state == WRAP) || (r_state == EMIT);
    assign w_is_shift   = (scan_in == SC_LSHIFT) || (scan_in == SC_RSHIFT);
    assign w_is_caps    = (scan_in == SC_CAPS);
    // Tracker judges the fresh mapping in MAP, and the code on the bus otherwise
    assign w_trk_code   = (r_state == MAP) ? map_code : r_lcd_data;
    assign w_trk_accept = w_accept && ((r_state == WRAP) || (r_state == EMIT));
    // Enter on line 1 becomes a jump to line 0; wrap_cmd already encodes that
    assign w_map_sel    = (map_code == LCD_LINE1) ? w_wrap_cmd : map_code;

    kbd_cursor_tracker #(.LCD_COLS(LCD_COLS)) u_cursor (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_code      (w_trk_code),
        .i_accept    (w_trk_accept),
        .o_need_wrap (w_need_wrap),
        .o_wrap_cmd  (w_wrap_cmd)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (scan_valid) begin
                if (scan_in == SC_BREAK)
                    w_state_nxt = BRK;
                else if (scan_in == SC_EXT)
                    w_state_nxt = EXT;
                else if (!w_is_shift && !w_is_caps)
                    w_state_nxt = MAP;
            end
            BRK:     if (scan_valid) w_state_nxt = IDLE;
            EXT:     if (scan_valid) w_state_nxt = (scan_in == SC_BREAK) ? EXT_BRK : IDLE;
            EXT_BRK: if (scan_valid) w_state_nxt = IDLE;
            MAP:     w_state_nxt = w_need_wrap ? WRAP : EMIT;
            WRAP:    if (w_accept) w_state_nxt = EMIT;
            EMIT:    if (w_accept) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kcode     <= '0;
            r_shift     <= 1'b0;
            r_caps      <= 1'b0;
            r_lcd_data  <= '0;
            r_lcd_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_pend      <= '0;
        end else begin
            if (scan_valid && w_busy)
                r_overrun <= 1'b1;

            if (scan_valid && r_state == IDLE) begin
                if (w_is_shift)
                    r_shift <= 1'b1;
                else if (w_is_caps)
                    r_caps <= ~r_caps;
                else if (w_state_nxt == MAP)
                    r_kcode <= scan_in;
            end

            if (scan_valid && r_state == BRK && w_is_shift)
                r_shift <= 1'b0;

            case (r_state)
                MAP: begin
                    r_lcd_valid <= 1'b1;
                    r_lcd_data  <= w_need_wrap ? w_wrap_cmd : w_map_sel;
                    r_pend      <= map_code;
                end
                WRAP: if (w_accept) r_lcd_data  <= r_pend;
                EMIT: if (w_accept) r_lcd_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign kcode       = r_kcode;
    assign letter_case = r_shift ^ r_caps;
    assign lcd_data    = r_lcd_data;
    assign lcd_valid   = r_lcd_valid;
    assign caps_led    = r_caps;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_kbd_lcd_sequencer.sv
// Self-checking bench: key2lcd stand-in, output scoreboard, table of key
// vectors, and hand sequences for latency, wrap, stall and reset abort.
module tb_kbd_lcd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] scan_in = '0;
    logic       scan_valid = 1'b0;
    logic [7:0] kcode;
    logic       letter_case;
    logic [8:0] map_code;
    logic [8:0] lcd_data;
    logic       lcd_valid;
    logic       lcd_ready = 1'b1;
    logic       caps_led;
    logic       overrun;

    int tests = 0;
    int fails = 0;
    logic [8:0] q[$];

    always #5 clk = ~clk;

    kbd_lcd_sequencer #(.LCD_COLS(16)) dut (
        .clk(clk), .rst(rst), .scan_in(scan_in), .scan_valid(scan_valid),
        .kcode(kcode), .letter_case(letter_case), .map_code(map_code),
        .lcd_data(lcd_data), .lcd_valid(lcd_valid), .lcd_ready(lcd_ready),
        .caps_led(caps_led), .overrun(overrun)
    );

    // key2lcd stand-in
    always_comb begin
        case (kcode)
            8'h1C:   map_code = letter_case ? 9'h141 : 9'h001;
            8'h32:   map_code = letter_case ? 9'h142 : 9'h002;
            8'h5A:   map_code = 9'h0C0;
            8'h66:   map_code = 9'h108;
            8'h0D:   map_code = 9'h109;
            default: map_code = 9'h120;
        endcase
    end

    // Scoreboard: every accepted LCD code must match the next expected one
    always @(negedge clk) begin
        if (!rst && lcd_valid && lcd_ready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL lcd_out_unexpected got=%h want=none", lcd_data);
            end else begin
                logic [8:0] e;
                e = q.pop_front();
                if (lcd_data !== e) begin
                    fails++;
                    $display("FAIL lcd_out got=%h want=%h", lcd_data, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        scan_in = b;
        scan_valid = 1'b1;
        @(posedge clk); #1;
        scan_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || lcd_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0 || lcd_valid) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout pending=%0d valid=%0b", q.size(), lcd_valid);
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !lcd_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("valid_timeout", 32'(lcd_valid), 32'd1);
    endtask

    task automatic key(input logic [7:0] sc, input logic [8:0] a, input logic [8:0] b, input int n);
        if (n > 0) q.push_back(a);
        if (n > 1) q.push_back(b);
        send_byte(sc);
        repeat (3) @(posedge clk);
        #1;
        wait_idle();
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0] sc;
        logic       has_out;
        logic [8:0] exp;
        logic       lc;
    } vec_t;

    vec_t tbl[24];

    initial begin
        tbl[0]  = '{8'h12, 1'b0, 9'h000, 1'b1};
        tbl[1]  = '{8'h1C, 1'b1, 9'h141, 1'b1};
        tbl[2]  = '{8'hF0, 1'b0, 9'h000, 1'b1};
        tbl[3]  = '{8'h12, 1'b0, 9'h000, 1'b0};
        tbl[4]  = '{8'h1C, 1'b1, 9'h001, 1'b0};
        tbl[5]  = '{8'h58, 1'b0, 9'h000, 1'b1};
        tbl[6]  = '{8'hF0, 1'b0, 9'h000, 1'b1};
        tbl[7]  = '{8'h58, 1'b0, 9'h000, 1'b1};
        tbl[8]  = '{8'h1C, 1'b1, 9'h141, 1'b1};
        tbl[9]  = '{8'h58, 1'b0, 9'h000, 1'b0};
        tbl[10] = '{8'h1C, 1'b1, 9'h001, 1'b0};
        tbl[11] = '{8'h59, 1'b0, 9'h000, 1'b1};
        tbl[12] = '{8'hF0, 1'b0, 9'h000, 1'b1};
        tbl[13] = '{8'h59, 1'b0, 9'h000, 1'b0};
        tbl[14] = '{8'h5A, 1'b1, 9'h0C0, 1'b0};
        tbl[15] = '{8'h5A, 1'b1, 9'h080, 1'b0};
        tbl[16] = '{8'h66, 1'b1, 9'h108, 1'b0};
        tbl[17] = '{8'h0D, 1'b1, 9'h109, 1'b0};
        tbl[18] = '{8'hE0, 1'b0, 9'h000, 1'b0};
        tbl[19] = '{8'h75, 1'b0, 9'h000, 1'b0};
        tbl[20] = '{8'hE0, 1'b0, 9'h000, 1'b0};
        tbl[21] = '{8'hF0, 1'b0, 9'h000, 1'b0};
        tbl[22] = '{8'h75, 1'b0, 9'h000, 1'b0};
        tbl[23] = '{8'h1C, 1'b1, 9'h001, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_kcode",    32'(kcode),       32'h0);
        chk("rst_case",     32'(letter_case), 32'h0);
        chk("rst_lcd_data", 32'(lcd_data),    32'h0);
        chk("rst_valid",    32'(lcd_valid),   32'h0);
        chk("rst_caps",     32'(caps_led),    32'h0);
        chk("rst_overrun",  32'(overrun),     32'h0);

        // Two-cycle latency from the scan strobe to lcd_valid
        @(posedge clk); #1;
        q.push_back(9'h001);
        scan_in = 8'h1C;
        scan_valid = 1'b1;
        @(posedge clk); #1;
        scan_valid = 1'b0;
        chk("lat_n1_kcode", 32'(kcode),     32'h1C);
        chk("lat_n1_valid", 32'(lcd_valid), 32'h0);
        @(posedge clk); #1;
        chk("lat_n2_valid", 32'(lcd_valid), 32'h1);
        chk("lat_n2_data",  32'(lcd_data),  32'h001);
        wait_idle();

        for (int i = 0; i < 24; i++) begin
            key(tbl[i].sc, tbl[i].exp, 9'h000, tbl[i].has_out ? 1 : 0);
            chk($sformatf("vec%0d_case", i), 32'(letter_case), 32'(tbl[i].lc));
        end
        chk("vec_overrun", 32'(overrun), 32'h0);

        // Backspace saturates at col 0, tab holds col, wraps alternate lines
        reset_dut();
        key(8'h66, 9'h108, 9'h000, 1);
        for (int i = 0; i < 16; i++) key(8'h1C, 9'h001, 9'h000, 1);
        key(8'h0D, 9'h109, 9'h000, 1);
        key(8'h1C, 9'h0C0, 9'h001, 2);
        for (int i = 0; i < 15; i++) key(8'h1C, 9'h001, 9'h000, 1);
        key(8'h66, 9'h108, 9'h000, 1);
        key(8'h1C, 9'h001, 9'h000, 1);
        key(8'h1C, 9'h080, 9'h001, 2);

        // Stall with a byte arriving mid-wait: it is dropped and flagged
        lcd_ready = 1'b0;
        q.push_back(9'h001);
        send_byte(8'h1C);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            scan_in = 8'h32;
            scan_valid = (i == 1);
            @(posedge clk); #1;
            chk("stall_valid", 32'(lcd_valid), 32'h1);
            chk("stall_data",  32'(lcd_data),  32'h001);
        end
        scan_valid = 1'b0;
        chk("stall_overrun", 32'(overrun), 32'h1);
        lcd_ready = 1'b1;
        wait_idle();
        repeat (6) @(posedge clk);
        #1;

        // Fill line 0 (col is 2 here), then reset while the wrap is pending
        key(8'h58, 9'h000, 9'h000, 0);
        chk("caps_on", 32'(caps_led), 32'h1);
        for (int i = 0; i < 14; i++) key(8'h1C, 9'h141, 9'h000, 1);
        lcd_ready = 1'b0;
        send_byte(8'h1C);
        wait_valid();
        chk("wrap_cmd", 32'(lcd_data), 32'h0C0);
        chk("overrun_sticky", 32'(overrun), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_kcode",    32'(kcode),       32'h0);
        chk("abort_case",     32'(letter_case), 32'h0);
        chk("abort_lcd_data", 32'(lcd_data),    32'h0);
        chk("abort_valid",    32'(lcd_valid),   32'h0);
        chk("abort_caps",     32'(caps_led),    32'h0);
        chk("abort_overrun",  32'(overrun),     32'h0);
        rst = 1'b0;
        lcd_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        key(8'h1C, 9'h001, 9'h000, 1);

        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
